// File: rtl/cmos_cfg_pkg.sv
// Shared definitions for the CMOS sensor register configuration sequencer.
//   - FSM state encoding (legacy-compatible 4-bit constants)
//   - DLY_ADDR marker: an all-ones address turns a table entry into a delay
//   - cfg_entry_t: one table entry {addr, data}. It is stored at the widest
//     supported width (16/16), and the sequencer keeps the low ADDR_W/DATA_W bits.
//   - reg_wr / reg_dly: helpers that keep sensor tables readable
package cmos_cfg_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_PWUP     = 4'd1;
  localparam state_t ST_ISSUE    = 4'd2;
  localparam state_t ST_WR_WAIT  = 4'd3;
  localparam state_t ST_DELAY    = 4'd4;
  localparam state_t ST_NEXT     = 4'd5;
  localparam state_t ST_DONE     = 4'd6;
  localparam state_t ST_RD_ISSUE = 4'd7;
  localparam state_t ST_RD_WAIT  = 4'd8;

  localparam int CFG_ADDR_MAX_W = 16;
  localparam int CFG_DATA_MAX_W = 16;

  localparam logic [CFG_ADDR_MAX_W-1:0] DLY_ADDR = '1;

  typedef struct packed {
    logic [CFG_ADDR_MAX_W-1:0] addr;
    logic [CFG_DATA_MAX_W-1:0] data;
  } cfg_entry_t;

  function automatic cfg_entry_t reg_wr(input logic [CFG_ADDR_MAX_W-1:0] a,
                                        input logic [CFG_DATA_MAX_W-1:0] d);
    cfg_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  function automatic cfg_entry_t reg_dly(input logic [CFG_DATA_MAX_W-1:0] units);
    cfg_entry_t e;
    e.addr = DLY_ADDR;
    e.data = units;
    return e;
  endfunction

endpackage

// File: rtl/cmos_reg_config_if.sv
// Request/response bundle between the configuration sequencer and the SCCB master.
//   master modport: the sequencer (drives addr/wdata/wr_en/rd_en)
//   slave modport : the SCCB master (drives rdy/rdata/rdata_vld)
//
// Handshake: rdy=1 means the SCCB master is idle and can take one request.
// The sequencer raises wr_en or rd_en for exactly one cycle, only after it has
// seen rdy=1. It never raises both together. addr/wdata are stable while the
// request is outstanding. The master drops rdy while it works and raises it
// again when done. For a read it pulses rdata_vld for one cycle with rdata.
interface cmos_reg_config_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rdy;
  logic [DATA_W-1:0] rdata;
  logic              rdata_vld;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;

  modport master (
    input  rdy, rdata, rdata_vld,
    output wdata, addr, wr_en, rd_en
  );

  modport slave (
    output rdy, rdata, rdata_vld,
    input  wdata, addr, wr_en, rd_en
  );
endinterface

// File: rtl/cmos_reg_table.sv
// Combinational register table: index in, {addr, data} out.
//   idx   : table index
//   entry : cfg_entry_t at that index (delay entries use addr = DLY_ADDR)
// This file holds the sensor-specific contents. Replace it per sensor; the
// sequencer does not change. Indices past the last programmed entry return a
// zero-length delay, so a deeper TABLE_DEPTH degrades to harmless no-ops.
module cmos_reg_table
  import cmos_cfg_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = reg_dly(16'h0000);
    case (int'(idx))
      0:       entry = reg_wr(16'h0012, 16'h0080);  // COM7: soft reset
      1:       entry = reg_dly(16'h0002);           // settle after reset
      2:       entry = reg_wr(16'h0011, 16'h0001);  // CLKRC: prescaler
      3:       entry = reg_wr(16'h003A, 16'h0004);  // TSLB: output sequence
      default: ;
    endcase
  end

endmodule

// File: rtl/cmos_reg_config.sv
// CMOS sensor register configuration sequencer.
// After config_en, the block holds the power-up sequence on pwdn. It then walks
// the register table and writes every entry to the SCCB master. Delay entries
// wait instead of writing. When the last entry is done, the block raises cmos_en.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   config_en      : one-cycle start pulse (ignored while a sequence runs)
//   bus            : cmos_reg_config_if.master towards the SCCB master
//   cmos_en        : configuration complete, held until the next config_en
//   pwdn           : sensor power-down
//   busy           : sequence in progress
//   err, err_idx   : sticky verify failure and index of the first failing entry
//   dbg_state      : current FSM state
// Optional feature: define CMOS_CFG_VERIFY_EN to read every written register
// back. A mismatch rewrites the entry up to MAX_RETRY times before err is set.
// Without the macro, rd_en, err and err_idx are constant 0.
module cmos_reg_config
  import cmos_cfg_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int TABLE_DEPTH  = 165,
  parameter int IDX_W        = 8,
  parameter int PWUP_CYC     = 50000,
  parameter int DLY_UNIT_CYC = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               config_en,
  cmos_reg_config_if.master  bus,
  output logic               cmos_en,
  output logic               pwdn,
  output logic               busy,
  output logic               err,
  output logic [IDX_W-1:0]   err_idx,
  output state_t             dbg_state
);

  // pwdn is high for the first half of the power-up window and low for the second.
  localparam logic [31:0]      PWUP_HALF = 32'(PWUP_CYC / 2);
  localparam logic [31:0]      PWUP_FULL = 32'((PWUP_CYC / 2) * 2);
  localparam logic [31:0]      DLY_UNIT  = 32'(DLY_UNIT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TABLE_DEPTH - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       cnt;
  logic              skip;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_en_q;

  cfg_entry_t        ent;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              ent_is_dly;
  logic              unused_ent;

  cmos_reg_table #(.IDX_W(IDX_W)) u_table (
    .idx   (idx),
    .entry (ent)
  );

  assign ent_addr   = ent.addr[ADDR_W-1:0];
  assign ent_data   = ent.data[DATA_W-1:0];
  assign ent_is_dly = (ent_addr == DLY_ADDR[ADDR_W-1:0]);
  assign unused_ent = ^ent;

`ifdef CMOS_CFG_VERIFY_EN
  logic             rd_en_q;
  logic [7:0]       retry;
  logic             err_q;
  logic [IDX_W-1:0] err_idx_q;

  assign bus.rd_en = rd_en_q;
  assign err       = err_q;
  assign err_idx   = err_idx_q;
`else
  logic unused_rd;
  localparam int unused_max_retry = MAX_RETRY;

  assign bus.rd_en = 1'b0;
  assign err       = 1'b0;
  assign err_idx   = '0;
  assign unused_rd = ^{bus.rdata, bus.rdata_vld};
`endif

  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wr_en = wr_en_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      skip      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      cmos_en   <= 1'b0;
      pwdn      <= 1'b1;
      busy      <= 1'b0;
`ifdef CMOS_CFG_VERIFY_EN
      rd_en_q   <= 1'b0;
      retry     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
`endif
    end else begin
      // Requests are single-cycle pulses.
      wr_en_q <= 1'b0;
`ifdef CMOS_CFG_VERIFY_EN
      rd_en_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (config_en) begin
            state   <= ST_PWUP;
            idx     <= '0;
            cnt     <= '0;
            cmos_en <= 1'b0;
            busy    <= 1'b1;
            pwdn    <= 1'b1;
`ifdef CMOS_CFG_VERIFY_EN
            retry     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
`endif
          end
        end

        ST_PWUP: begin
          cnt <= cnt + 32'd1;
          if (cnt + 32'd1 == PWUP_HALF) pwdn <= 1'b0;
          if (cnt + 32'd1 == PWUP_FULL) begin
            cnt   <= '0;
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (ent_is_dly) begin
            cnt   <= 32'(ent_data) * DLY_UNIT;
            state <= ST_DELAY;
          end else if (bus.rdy) begin
            addr_q  <= ent_addr;
            wdata_q <= ent_data;
            wr_en_q <= 1'b1;
            skip    <= 1'b1;
            state   <= ST_WR_WAIT;
          end
        end

        // The first cycle is skipped. This gives the master time to drop rdy
        // for the request it has just taken.
        ST_WR_WAIT: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (bus.rdy) begin
`ifdef CMOS_CFG_VERIFY_EN
            state <= ST_RD_ISSUE;
`else
            state <= ST_NEXT;
`endif
          end
        end

        // A zero-unit delay still spends one cycle here.
        ST_DELAY: begin
          if (cnt <= 32'd1) state <= ST_NEXT;
          else              cnt   <= cnt - 32'd1;
        end

        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_ISSUE;
          end
        end

        ST_DONE: begin
          cmos_en <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end

`ifdef CMOS_CFG_VERIFY_EN
        // addr_q still holds the register that was just written.
        ST_RD_ISSUE: begin
          if (bus.rdy) begin
            rd_en_q <= 1'b1;
            state   <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (bus.rdata_vld) begin
            if (bus.rdata == ent_data) begin
              retry <= '0;
              state <= ST_NEXT;
            end else if (retry < 8'(MAX_RETRY)) begin
              retry <= retry + 8'd1;
              state <= ST_ISSUE;
            end else begin
              retry <= '0;
              err_q <= 1'b1;
              if (!err_q) err_idx_q <= idx;
              state <= ST_NEXT;
            end
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
